// File: rtl/branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit_pkg
// Description : Shared definitions for the branch unit: MIPS branch opcode
//               and REGIMM rt encodings, the 2-bit BHT counter type with its
//               reset value, and the saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_unit_pkg;

    // Primary opcodes of the conditional branches
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // REGIMM sub-operations selected by the rt field
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // 2-bit saturating counter; bit 1 is the predicted direction
    typedef logic [1:0] cnt_t;
    localparam cnt_t CNT_WNT = 2'b01;

    // Move the counter one step towards the resolved direction, saturating
    // at both ends.
    function automatic cnt_t cnt_next(input cnt_t cur, input logic taken);
        cnt_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage : branch_unit_pkg
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_bht
// Description : Branch history table of DEPTH 2-bit saturating counters.
//               One combinational read port (prediction) and one write port
//               (resolved outcome). A read of the entry being written in the
//               same cycle returns the value before the update.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               rd_idx_i        - prediction lookup index
//               rd_taken_o      - MSB of the addressed counter
//               wr_en_i         - apply an update this edge
//               wr_idx_i        - index of the counter to update
//               wr_taken_i      - resolved direction (inc when 1, dec when 0)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_bht
    import branch_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    // All counters flattened so the read port is a single variable index
    logic [2*DEPTH-1:0] cnt_flat;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            cnt_t cnt_q;
            cnt_t cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                    cnt_d = cnt_next(cnt_q, wr_taken_i);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= CNT_WNT;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_flat[2*gi +: 2] = cnt_q;
        end
    endgenerate

    // Bit 1 of entry n sits at position 2n+1
    assign rd_taken_o = cnt_flat[{rd_idx_i, 1'b1}];

endmodule : branch_bht
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : ID-stage branch resolution for MIPS conditional branches.
//               Decodes BEQ/BNE/BLEZ/BGTZ and the REGIMM BLTZ/BGEZ/BLTZAL/
//               BGEZAL forms, computes target and link addresses, registers
//               the outcome into the EX boundary and flags mispredictions.
//               Owns the BHT that IF reads for its prediction.
//               Optional feature macro: BRANCH_STATS_EN (resolved-branch and
//               mispredict counters; tied to 0 when undefined).
// Parameters  : DATA_W    - operand width
//               PC_W      - program counter width (at least 19)
//               BHT_DEPTH - BHT entries, power of two, at least 2
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               stall_i, flush_i  - hazard unit hold / kill-ID controls
//               if_pc_i           - fetch PC, pred_taken_o its prediction
//               id_*              - ID instruction fields and operands
//               ex_*              - registered branch outcome
//               mispredict_o, redirect_pc_o - recovery request
//               branch_cnt_o, mispred_cnt_o - statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   if_pc_i,
    output logic              pred_taken_o,
    input  logic              id_valid_i,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic [5:0]        id_op_i,
    input  logic [4:0]        id_rt_i,
    input  logic [15:0]       id_imm_i,
    input  logic [DATA_W-1:0] id_a_i,
    input  logic [DATA_W-1:0] id_b_i,
    input  logic              id_pred_i,
    output logic              ex_valid_o,
    output logic              ex_taken_o,
    output logic              ex_link_o,
    output logic [PC_W-1:0]   ex_link_addr_o,
    output logic              mispredict_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // ------------------------------------------------------------------
    // Decode and compare
    // ------------------------------------------------------------------
    logic w_is_branch;
    logic w_taken;
    logic w_link;
    logic w_a_neg;
    logic w_a_zero;

    // Sign tests look only at the MSB of rs; no unsigned compare is used.
    assign w_a_neg  = id_a_i[DATA_W-1];
    assign w_a_zero = (id_a_i == '0);

    always_comb begin
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        w_link      = 1'b0;
        case (id_op_i)
            OP_BEQ: begin
                w_is_branch = 1'b1;
                w_taken     = (id_a_i == id_b_i);
            end
            OP_BNE: begin
                w_is_branch = 1'b1;
                w_taken     = (id_a_i != id_b_i);
            end
            OP_BLEZ: begin
                w_is_branch = 1'b1;
                w_taken     = w_a_neg | w_a_zero;
            end
            OP_BGTZ: begin
                w_is_branch = 1'b1;
                w_taken     = ~w_a_neg & ~w_a_zero;
            end
            OP_REGIMM: begin
                case (id_rt_i)
                    RT_BLTZ: begin
                        w_is_branch = 1'b1;
                        w_taken     = w_a_neg;
                    end
                    RT_BGEZ: begin
                        w_is_branch = 1'b1;
                        w_taken     = ~w_a_neg;
                    end
                    RT_BLTZAL: begin
                        w_is_branch = 1'b1;
                        w_taken     = w_a_neg;
                        w_link      = 1'b1;
                    end
                    RT_BGEZAL: begin
                        w_is_branch = 1'b1;
                        w_taken     = ~w_a_neg;
                        w_link      = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address arithmetic (wraps modulo 2^PC_W)
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_link_addr;

    assign w_offset    = {{(PC_W-18){id_imm_i[15]}}, id_imm_i, 2'b00};
    assign w_target    = id_pc_i + PC_W'(4) + w_offset;
    assign w_link_addr = id_pc_i + PC_W'(8);

    // ------------------------------------------------------------------
    // EX boundary registers
    // ------------------------------------------------------------------
    logic             ex_valid_q,     ex_valid_d;
    logic             ex_taken_q,     ex_taken_d;
    logic             ex_link_q,      ex_link_d;
    logic             ex_pred_q,      ex_pred_d;
    logic [PC_W-1:0]  ex_target_q,    ex_target_d;
    logic [PC_W-1:0]  ex_link_addr_q, ex_link_addr_d;
    logic [IDX_W-1:0] ex_idx_q,       ex_idx_d;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_taken_d     = ex_taken_q;
        ex_link_d      = ex_link_q;
        ex_pred_d      = ex_pred_q;
        ex_target_d    = ex_target_q;
        ex_link_addr_d = ex_link_addr_q;
        ex_idx_d       = ex_idx_q;
        if (!stall_i) begin
            ex_valid_d     = id_valid_i & w_is_branch;
            ex_taken_d     = w_taken;
            ex_link_d      = w_link;
            ex_pred_d      = id_pred_i;
            ex_target_d    = w_target;
            ex_link_addr_d = w_link_addr;
            ex_idx_d       = id_pc_i[IDX_W+1:2];
        end
        // Flush overrides stall: a held branch is dropped as well, which
        // also means it never reaches the BHT.
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_taken_q     <= 1'b0;
            ex_link_q      <= 1'b0;
            ex_pred_q      <= 1'b0;
            ex_target_q    <= '0;
            ex_link_addr_q <= '0;
            ex_idx_q       <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_taken_q     <= ex_taken_d;
            ex_link_q      <= ex_link_d;
            ex_pred_q      <= ex_pred_d;
            ex_target_q    <= ex_target_d;
            ex_link_addr_q <= ex_link_addr_d;
            ex_idx_q       <= ex_idx_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_taken_o     = ex_taken_q;
    assign ex_link_o      = ex_link_q;
    assign ex_link_addr_o = ex_link_addr_q;
    assign mispredict_o   = ex_valid_q & (ex_taken_q ^ ex_pred_q);
    assign redirect_pc_o  = !ex_valid_q ? '0 :
                            (ex_taken_q ? ex_target_q : ex_link_addr_q);

    // ------------------------------------------------------------------
    // BHT: updated once per resolved branch, on the edge it leaves EX
    // ------------------------------------------------------------------
    logic w_bht_we;
    assign w_bht_we = ex_valid_q & ~stall_i;

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_pc_i[IDX_W+1:2]),
        .rd_taken_o (pred_taken_o),
        .wr_en_i    (w_bht_we),
        .wr_idx_i   (ex_idx_q),
        .wr_taken_i (ex_taken_q)
    );

    // Fetch PC bits outside the BHT index do not take part in prediction
    logic w_unused_if_pc;
    assign w_unused_if_pc = ^{if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q,  branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (w_bht_we) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (mispredict_o) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign branch_cnt_o  = 32'd0;
    assign mispred_cnt_o = 32'd0;
`endif

endmodule : branch_unit
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Self-checking bench for branch_unit. Directed scenarios
//               followed by randomized traffic, compared against a
//               behavioural model using signed integer arithmetic and an
//               array of counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [5:0]  id_op_i;
    logic [4:0]  id_rt_i;
    logic [15:0] id_imm_i;
    logic [31:0] id_a_i, id_b_i;
    logic        id_pred_i;
    logic        ex_valid_o, ex_taken_o, ex_link_o, mispredict_o;
    logic [31:0] ex_link_addr_o, redirect_pc_o, branch_cnt_o, mispred_cnt_o;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .if_pc_i        (if_pc_i),
        .pred_taken_o   (pred_taken_o),
        .id_valid_i     (id_valid_i),
        .id_pc_i        (id_pc_i),
        .id_op_i        (id_op_i),
        .id_rt_i        (id_rt_i),
        .id_imm_i       (id_imm_i),
        .id_a_i         (id_a_i),
        .id_b_i         (id_b_i),
        .id_pred_i      (id_pred_i),
        .ex_valid_o     (ex_valid_o),
        .ex_taken_o     (ex_taken_o),
        .ex_link_o      (ex_link_o),
        .ex_link_addr_o (ex_link_addr_o),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .branch_cnt_o   (branch_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          bht [64];
    bit          m_valid, m_taken, m_link, m_pred;
    logic [31:0] m_pc, m_target, m_la;
    int unsigned n_br, n_mis;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        foreach (bht[i]) bht[i] = 1;
        m_valid = 0; m_taken = 0; m_link = 0; m_pred = 0;
        m_pc = 0; m_target = 0; m_la = 0;
        n_br = 0; n_mis = 0;
    endtask

    task automatic decode(input logic [5:0] op, input logic [4:0] rt,
                          input logic [31:0] a, input logic [31:0] b,
                          output bit br, output bit tk, output bit lk);
        int sa;
        sa = $signed(a);
        br = 0; tk = 0; lk = 0;
        if (op == 6'd4)      begin br = 1; tk = (a == b); end
        else if (op == 6'd5) begin br = 1; tk = (a != b); end
        else if (op == 6'd6) begin br = 1; tk = (sa <= 0); end
        else if (op == 6'd7) begin br = 1; tk = (sa > 0);  end
        else if (op == 6'd1) begin
            if (rt == 5'd0)       begin br = 1; tk = (sa < 0); end
            else if (rt == 5'd1)  begin br = 1; tk = (sa >= 0); end
            else if (rt == 5'd16) begin br = 1; tk = (sa < 0);  lk = 1; end
            else if (rt == 5'd17) begin br = 1; tk = (sa >= 0); lk = 1; end
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", ex_valid_o, m_valid);
        if (m_valid) begin
            check("ex_taken", ex_taken_o, m_taken);
            check("ex_link", ex_link_o, m_link);
            check("ex_link_addr", ex_link_addr_o, m_la);
            check("mispredict", mispredict_o, m_taken != m_pred);
            check("redirect", redirect_pc_o, m_taken ? m_target : m_la);
        end else begin
            check("mispredict_idle", mispredict_o, 0);
            check("redirect_idle", redirect_pc_o, 0);
        end
        check("branch_cnt", branch_cnt_o, STATS ? n_br : 0);
        check("mispred_cnt", mispred_cnt_o, STATS ? n_mis : 0);
    endtask

    // One clock: check prediction with current inputs, advance the model
    // through the edge, then check registered outputs.
    task automatic cycle();
        bit br, tk, lk;
        int off;
        #1;
        check("pred_taken", pred_taken_o, bht[idx(if_pc_i)] >= 2);
        decode(id_op_i, id_rt_i, id_a_i, id_b_i, br, tk, lk);
        if (m_valid && !stall_i) begin
            if (m_taken) bht[idx(m_pc)] = (bht[idx(m_pc)] < 3) ? bht[idx(m_pc)] + 1 : 3;
            else         bht[idx(m_pc)] = (bht[idx(m_pc)] > 0) ? bht[idx(m_pc)] - 1 : 0;
            n_br++;
            if (m_taken != m_pred) n_mis++;
        end
        if (!stall_i) begin
            off      = $signed(id_imm_i);
            m_valid  = id_valid_i && br;
            m_taken  = tk;
            m_link   = lk;
            m_pred   = id_pred_i;
            m_pc     = id_pc_i;
            m_target = id_pc_i + 32'd4 + 32'(off * 4);
            m_la     = id_pc_i + 32'd8;
        end
        if (flush_i) m_valid = 0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                      input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                      input bit pred);
        id_valid_i = 1; id_op_i = op; id_rt_i = rt; id_pc_i = pc; id_imm_i = imm;
        id_a_i = a; id_b_i = b; id_pred_i = pred;
        stall_i = 0; flush_i = 0; if_pc_i = pc;
        cycle();
    endtask

    task automatic idle();
        id_valid_i = 0; stall_i = 0; flush_i = 0;
        cycle();
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: return 32'hffff_ffff;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'd4;
            1: return 6'd5;
            2: return 6'd6;
            3: return 6'd7;
            4, 5: return 6'd1;
            6: return 6'd2;
            default: return 6'($urandom());
        endcase
    endfunction

    function automatic logic [4:0] pick_rt();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd16;
            3: return 5'd17;
            default: return 5'($urandom());
        endcase
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] hi;
        hi = $urandom();
        return {hi[31:8], 3'd0, 3'($urandom_range(0, 7)), 2'b00};
    endfunction

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; if_pc_i = 0; id_valid_i = 0;
        id_pc_i = 0; id_op_i = 0; id_rt_i = 0; id_imm_i = 0;
        id_a_i = 0; id_b_i = 0; id_pred_i = 0;
        model_reset();
        #12;
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_pred", pred_taken_o, 0);
        @(negedge clk);
        rst = 0;

        // BGEZ on the most negative value, predicted taken
        br(6'd1, 5'd1, 32'h0000_1000, 16'h0010, 32'h8000_0000, 32'h0, 1'b1);
        check("bgez_neg_taken", ex_taken_o, 0);
        check("bgez_neg_mispred", mispredict_o, 1);
        check("bgez_neg_redirect", redirect_pc_o, 32'h0000_1008);
        idle();

        // BNE equal then unequal; imm = -1 targets the branch itself
        br(6'd5, 5'd0, 32'h0000_2000, 16'hFFFF, 32'd5, 32'd5, 1'b0);
        check("bne_eq_mispred", mispredict_o, 0);
        br(6'd5, 5'd0, 32'h0000_2004, 16'hFFFF, 32'd5, 32'd6, 1'b0);
        check("bne_ne_redirect", redirect_pc_o, 32'h0000_2004);

        // Linking forms
        br(6'd1, 5'd17, 32'h0040_0010, 16'h0004, 32'd0, 32'd0, 1'b0);
        check("bgezal_link_addr", ex_link_addr_o, 32'h0040_0018);
        check("bgezal_link", ex_link_o, 1);
        br(6'd1, 5'd16, 32'h0040_0020, 16'h0004, 32'd1, 32'd0, 1'b0);
        check("bltzal_link", ex_link_o, 1);
        check("bltzal_taken", ex_taken_o, 0);
        idle();

        // Four taken branches at one index: saturate at 11
        for (int i = 0; i < 4; i++) br(6'd4, 5'd0, 32'h0000_3040, 16'h0002, 32'd7, 32'd7, 1'b1);
        idle();
        // Two not-taken from 11 leaves 01: prediction drops only on the second
        br(6'd4, 5'd0, 32'h0000_3040, 16'h0002, 32'd7, 32'd8, 1'b1);
        br(6'd4, 5'd0, 32'h0000_3040, 16'h0002, 32'd7, 32'd8, 1'b1);
        idle();

        // Taken branch held in EX by a 3-cycle stall updates once
        br(6'd7, 5'd0, 32'h0000_4050, 16'h0008, 32'd3, 32'd0, 1'b0);
        id_valid_i = 1; id_op_i = 6'd4; stall_i = 1;
        for (int i = 0; i < 3; i++) cycle();
        stall_i = 0; id_valid_i = 0;
        cycle();
        br(6'd6, 5'd0, 32'h0000_4050, 16'h0008, 32'd3, 32'd0, 1'b0);
        idle();
        idle();

        // Flush and stall together on a valid BEQ
        br(6'd4, 5'd0, 32'h0000_5000, 16'h0001, 32'd1, 32'd1, 1'b1);
        id_valid_i = 1; stall_i = 1; flush_i = 1;
        cycle();
        check("flush_stall_valid", ex_valid_o, 0);
        stall_i = 0; flush_i = 0; id_valid_i = 0;
        cycle();

        // Asynchronous reset while a branch is held by stall
        br(6'd4, 5'd0, 32'h0000_6010, 16'h0001, 32'd2, 32'd2, 1'b0);
        br(6'd4, 5'd0, 32'h0000_6010, 16'h0001, 32'd2, 32'd2, 1'b0);
        id_valid_i = 1; stall_i = 1;
        cycle();
        #2 rst = 1;
        #1;
        model_reset();
        check("arst_ex_valid", ex_valid_o, 0);
        check("arst_mispred", mispredict_o, 0);
        check("arst_redirect", redirect_pc_o, 0);
        check("arst_link_addr", ex_link_addr_o, 0);
        check("arst_branch_cnt", branch_cnt_o, 0);
        for (int i = 0; i < 64; i++) begin
            if_pc_i = 32'(i) << 2;
            #1 check("arst_pred", pred_taken_o, bht[i] >= 2);
        end
        @(negedge clk);
        rst = 0; stall_i = 0;
        // One taken update from 01 must flip the prediction
        br(6'd4, 5'd0, 32'h0000_6010, 16'h0001, 32'd2, 32'd2, 1'b0);
        idle();
        // J never produces a resolved branch
        br(6'd2, 5'd0, 32'h0000_7000, 16'h0001, 32'd0, 32'd0, 1'b0);
        check("j_not_branch", ex_valid_o, 0);

        // Statistics: 10 resolved branches, 3 mispredicted
        rst = 1;
        #1 model_reset();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++)
            br(6'd4, 5'd0, 32'h0000_8000 + 32'(i * 4), 16'h0001, 32'd9, 32'd9,
               (i == 0 || i == 3 || i == 6) ? 1'b0 : 1'b1);
        idle();
        check("stats_branches", branch_cnt_o, STATS ? 32'd10 : 32'd0);
        check("stats_mispred", mispred_cnt_o, STATS ? 32'd3 : 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            id_valid_i = ($urandom_range(0, 9) != 0);
            id_op_i    = pick_op();
            id_rt_i    = pick_rt();
            id_pc_i    = pick_pc();
            id_imm_i   = 16'($urandom());
            id_a_i     = pick_val();
            id_b_i     = ($urandom_range(0, 3) == 0) ? id_a_i : pick_val();
            id_pred_i  = $urandom_range(0, 1);
            stall_i    = ($urandom_range(0, 4) == 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            if_pc_i    = pick_pc();
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_unit
`default_nettype wire
